// File: rtl/sdlc_rx_deframer.sv
// SDLC receive deframer: samples the rx_clk/rx_data line pair, hunts for 0x7E
// flags, removes inserted zeros, detects aborts and assembles LSB-first 16-bit
// words with frame start/end status for the receive FIFO.
// Optional build macro: SDLC_RX_NRZI_EN (NRZI line decoding ahead of the
// ones counter).
module sdlc_rx_deframer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_BYTES   = 4,
  parameter int unsigned MAX_BYTES   = 256,
  localparam int unsigned CW         = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx_clk,
  input  logic          rx_data,
  input  logic          enable,
  input  logic          word_full,
  output logic [15:0]   word_data,
  output logic          word_valid,
  output logic          word_odd,
  output logic          frame_start,
  output logic          frame_end,
  output logic          frame_err,
  output logic [CW-1:0] byte_count,
  output logic          abort,
  output logic          overrun,
  output logic          in_frame
);

  localparam logic [CW-1:0] MIN_B  = CW'(MIN_BYTES);
  localparam logic [CW-1:0] MAX_B  = CW'(MAX_BYTES);
  localparam logic [CW-1:0] MAX_P1 = CW'(MAX_BYTES + 1);

  typedef enum logic [1:0] {HUNT, SYNC, FRAME} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, bit_event, line_bit;
  logic [2:0]             ones, ones_n;
  logic [6:0]             dly, dly_n;
  logic [2:0]             dly_cnt, dly_cnt_n;
  logic [15:0]            shreg, shreg_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [CW-1:0]          byte_cnt_n;
  logic [15:0]            word_data_n;
  logic                   word_valid_n, word_odd_n, frame_start_n, frame_end_n;
  logic                   frame_err_n, abort_n, overrun_n, in_frame_n;
  logic                   hit7, flag, stuff, dbit, exit_v, exit_bit;

  // Synchronise the line clock and data, remember the previous line clock level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], rx_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], rx_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign bit_event = clk_s & ~clk_prev;

`ifdef SDLC_RX_NRZI_EN
  logic nrzi_prev;

  // NRZI reference level, tracked on every bit event regardless of enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) nrzi_prev <= 1'b1;
    else if (bit_event) nrzi_prev <= data_s;
  end

  assign line_bit = (data_s == nrzi_prev);
`else
  assign line_bit = data_s;
`endif

  // Bit classification from the ones run preceding this bit
  assign hit7     = bit_event &  line_bit & (ones == 3'd6);
  assign flag     = bit_event & ~line_bit & (ones == 3'd6);
  assign stuff    = bit_event & ~line_bit & (ones == 3'd5);
  assign dbit     = bit_event & ~hit7 & ~flag & ~stuff;
  assign exit_v   = dbit & (dly_cnt == 3'd7);
  assign exit_bit = dly[6];

  // Registered state, datapath and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      ones        <= '0;
      dly         <= '0;
      dly_cnt     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      byte_count  <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      word_odd    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      abort       <= 1'b0;
      overrun     <= 1'b0;
      in_frame    <= 1'b0;
    end else begin
      state       <= state_n;
      ones        <= ones_n;
      dly         <= dly_n;
      dly_cnt     <= dly_cnt_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      byte_count  <= byte_cnt_n;
      word_data   <= word_data_n;
      word_valid  <= word_valid_n;
      word_odd    <= word_odd_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
      frame_err   <= frame_err_n;
      abort       <= abort_n;
      overrun     <= overrun_n;
      in_frame    <= in_frame_n;
    end
  end

  // Next-state: ones counter, delay line, frame FSM and word assembly
  always_comb begin
    state_n       = state;
    ones_n        = ones;
    dly_n         = dly;
    dly_cnt_n     = dly_cnt;
    shreg_n       = shreg;
    bit_cnt_n     = bit_cnt;
    byte_cnt_n    = byte_count;
    word_data_n   = word_data;
    word_valid_n  = 1'b0;
    word_odd_n    = 1'b0;
    frame_start_n = 1'b0;
    frame_end_n   = 1'b0;
    frame_err_n   = 1'b0;
    abort_n       = 1'b0;
    overrun_n     = overrun | (word_valid & word_full);
    in_frame_n    = 1'b0;

    if (bit_event) begin
      if (line_bit) ones_n = (ones == 3'd7) ? 3'd7 : ones + 3'd1;
      else          ones_n = 3'd0;
    end

    // The flag's own 0 and six 1s sit in the delay line and are dropped here
    if (flag || hit7) begin
      dly_cnt_n = 3'd0;
    end else if (dbit) begin
      dly_n = {dly[5:0], line_bit};
      if (dly_cnt != 3'd7) dly_cnt_n = dly_cnt + 3'd1;
    end

    case (state)
      HUNT: begin
        if (flag) state_n = SYNC;
      end
      SYNC: begin
        if (hit7) begin
          state_n = HUNT;
        end else if (exit_v) begin
          state_n       = FRAME;
          frame_start_n = 1'b1;
          overrun_n     = 1'b0;
          shreg_n       = {exit_bit, 15'd0};
          bit_cnt_n     = 4'd1;
          byte_cnt_n    = '0;
        end
      end
      FRAME: begin
        if (hit7) begin
          state_n = HUNT;
          abort_n = 1'b1;
        end else if (flag) begin
          state_n     = SYNC;
          frame_end_n = 1'b1;
          bit_cnt_n   = 4'd0;
          frame_err_n = !((bit_cnt == 4'd0) || (bit_cnt == 4'd8)) ||
                        (byte_count < MIN_B) || (byte_count > MAX_B) ||
                        overrun || (word_valid & word_full);
          if ((bit_cnt == 4'd8) && (byte_count <= MAX_B)) begin
            word_valid_n = 1'b1;
            word_odd_n   = 1'b1;
            word_data_n  = {8'h00, shreg[15:8]};
          end
        end else if (exit_v) begin
          shreg_n   = {exit_bit, shreg[15:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if ((bit_cnt[2:0] == 3'd7) && (byte_count != MAX_P1))
            byte_cnt_n = byte_count + CW'(1);
          if ((bit_cnt == 4'd15) && (byte_cnt_n <= MAX_B)) begin
            word_valid_n = 1'b1;
            word_data_n  = shreg_n;
          end
        end
      end
      default: state_n = HUNT;
    endcase

    // Receiver disabled: drop everything silently
    if (!enable) begin
      state_n       = HUNT;
      ones_n        = 3'd0;
      dly_n         = '0;
      dly_cnt_n     = 3'd0;
      shreg_n       = '0;
      bit_cnt_n     = 4'd0;
      byte_cnt_n    = '0;
      overrun_n     = 1'b0;
      word_valid_n  = 1'b0;
      word_odd_n    = 1'b0;
      frame_start_n = 1'b0;
      frame_end_n   = 1'b0;
      frame_err_n   = 1'b0;
      abort_n       = 1'b0;
    end

    in_frame_n = (state_n == FRAME);
  end

endmodule

// File: tb/tb_sdlc_rx_deframer.sv
// Self-checking bench for sdlc_rx_deframer: drives bit-stuffed SDLC frames on
// rx_clk/rx_data and checks emitted words and frame status against a queue of
// expected events.
module tb_sdlc_rx_deframer;

  localparam int unsigned CW = $clog2(256 + 1);

  logic          clk, reset_n, rx_clk, rx_data, enable, word_full;
  logic [15:0]   word_data;
  logic          word_valid, word_odd, frame_start, frame_end, frame_err;
  logic [CW-1:0] byte_count;
  logic          abort, overrun, in_frame;

  typedef struct {
    bit            is_end;
    logic [15:0]   data;
    bit            odd;
    bit            err;
    logic [CW-1:0] cnt;
    bit            ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks, n_fail;
  int   n_words, n_start, n_abort, n_end;
  int   cyc, last_odd_cyc, last_end_cyc;
  int   tx_ones;
  bit   ignore_words;

  sdlc_rx_deframer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_clk     (rx_clk),
    .rx_data    (rx_data),
    .enable     (enable),
    .word_full  (word_full),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_odd   (word_odd),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .frame_err  (frame_err),
    .byte_count (byte_count),
    .abort      (abort),
    .overrun    (overrun),
    .in_frame   (in_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sample on the falling edge and score any output events
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (frame_start) n_start++;
    if (abort) n_abort++;
    if (word_valid) begin
      n_words++;
      if (word_odd) last_odd_cyc = cyc;
      if (!ignore_words) begin
        n_checks++;
        if (exp_q.size() == 0 || exp_q[0].is_end) begin
          n_fail++;
          $display("FAIL word_unexpected: got data=%h odd=%b, required no word", word_data, word_odd);
        end else begin
          e = exp_q.pop_front();
          if (word_data !== e.data || word_odd !== e.odd) begin
            n_fail++;
            $display("FAIL word: got data=%h odd=%b, required data=%h odd=%b", word_data, word_odd, e.data, e.odd);
          end
        end
      end
    end
    if (frame_end) begin
      n_end++;
      last_end_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0 || !exp_q[0].is_end) begin
        n_fail++;
        $display("FAIL frame_end_unexpected: got frame_end=1 count=%0d, required no frame_end", byte_count);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.err) begin
          n_fail++;
          $display("FAIL frame_err: got %b, required %b", frame_err, e.err);
        end
        n_checks++;
        if (byte_count !== e.cnt) begin
          n_fail++;
          $display("FAIL byte_count: got %0d, required %0d", byte_count, e.cnt);
        end
        n_checks++;
        if (overrun !== e.ovr) begin
          n_fail++;
          $display("FAIL overrun_at_end: got %b, required %b", overrun, e.ovr);
        end
      end
    end
  endtask

  task automatic send_bit_raw(input logic b);
    rx_data = b;
    rx_clk  = 1'b0;
    repeat (4) step();
    rx_clk = 1'b1;
    repeat (4) step();
  endtask

  task automatic send_stuffed(input logic b);
    send_bit_raw(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_bit_raw(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic [7:0] s;
    s = v;
    for (int i = 0; i < 8; i++) begin
      send_stuffed(s[0]);
      s = s >> 1;
    end
  endtask

  task automatic send_flag();
    logic [7:0] s;
    s = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      send_bit_raw(s[0]);
      s = s >> 1;
    end
    tx_ones = 0;
  endtask

  task automatic idle(input int n);
    rx_clk  = 1'b0;
    rx_data = 1'b1;
    repeat (n) step();
  endtask

  task automatic push_word(input logic [15:0] d, input bit odd);
    exp_t e;
    e.is_end = 1'b0; e.data = d; e.odd = odd; e.err = 1'b0; e.cnt = '0; e.ovr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_end(input bit err, input int cnt, input bit ovr);
    exp_t e;
    e.is_end = 1'b1; e.data = '0; e.odd = 1'b0; e.err = err; e.cnt = CW'(cnt); e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  task automatic expect_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d pending expected events, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({word_valid, word_odd, frame_start, frame_end, frame_err, abort, overrun, in_frame} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000000",
               {word_valid, word_odd, frame_start, frame_end, frame_err, abort, overrun, in_frame});
    end
    n_checks++;
    if (word_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_word_data: got %h, required 0000", word_data);
    end
    n_checks++;
    if (byte_count !== '0) begin
      n_fail++;
      $display("FAIL reset_byte_count: got %0d, required 0", byte_count);
    end
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_idle_line();
    int a0;
    a0 = n_abort;
    for (int i = 0; i < 24; i++) send_bit_raw(1'b1);
    n_checks++;
    if (n_abort != a0 || in_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_line: got aborts=%0d in_frame=%b, required aborts=0 in_frame=0", n_abort - a0, in_frame);
    end
  endtask

  task automatic test_basic_frame();
    int s0;
    s0 = n_start;
    push_word(16'h2301, 1'b0);
    push_word(16'h6745, 1'b0);
    push_end(1'b0, 4, 1'b0);
    send_flag(); send_flag();
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
    send_flag();
    idle(8);
    n_checks++;
    if (n_start != s0 + 1) begin
      n_fail++;
      $display("FAIL basic_frame_start: got %0d starts, required 1", n_start - s0);
    end
    expect_drained("basic");
  endtask

  task automatic test_stuffing();
    int a0;
    a0 = n_abort;
    push_word(16'hFFFF, 1'b0);
    push_word(16'h001F, 1'b0);
    push_end(1'b0, 4, 1'b0);
    send_flag();
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h1F); send_byte(8'h00);
    send_flag();
    idle(8);
    n_checks++;
    if (n_abort != a0) begin
      n_fail++;
      $display("FAIL stuffing_abort: got %0d aborts, required 0", n_abort - a0);
    end
    expect_drained("stuffing");
  endtask

  task automatic test_odd_byte();
    push_word(16'h2301, 1'b0);
    push_word(16'h6745, 1'b0);
    push_word(16'h0089, 1'b1);
    push_end(1'b0, 5, 1'b0);
    last_odd_cyc = -1;
    last_end_cyc = -2;
    send_flag();
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67); send_byte(8'h89);
    send_flag();
    idle(8);
    n_checks++;
    if (last_odd_cyc != last_end_cyc) begin
      n_fail++;
      $display("FAIL odd_same_clk: got odd word cycle %0d, required frame_end cycle %0d", last_odd_cyc, last_end_cyc);
    end
    expect_drained("odd");
  endtask

  task automatic test_abort();
    int a0;
    a0 = n_abort;
    ignore_words = 1'b1;
    send_flag();
    send_byte(8'h01); send_byte(8'h23);
    for (int i = 0; i < 7; i++) send_bit_raw(1'b1);
    idle(6);
    n_checks++;
    if (n_abort != a0 + 1) begin
      n_fail++;
      $display("FAIL abort_pulse: got %0d aborts, required 1", n_abort - a0);
    end
    n_checks++;
    if (in_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_frame: got %b, required 0", in_frame);
    end
    ignore_words = 1'b0;
    push_word(16'hAB89, 1'b0);
    push_word(16'hEFCD, 1'b0);
    push_end(1'b0, 4, 1'b0);
    send_flag();
    send_byte(8'h89); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    send_flag();
    idle(8);
    expect_drained("abort");
  endtask

  task automatic test_bad_length();
    logic [11:0] r;
    push_word(16'h55AA, 1'b0);
    push_end(1'b1, 2, 1'b0);
    send_flag();
    send_byte(8'hAA); send_byte(8'h55);
    send_flag();
    idle(8);
    expect_drained("short");
    push_word(16'h2301, 1'b0);
    push_word(16'h6745, 1'b0);
    push_end(1'b1, 5, 1'b0);
    send_flag();
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
    r = 12'h0A5;
    for (int i = 0; i < 12; i++) begin
      send_stuffed(r[0]);
      r = r >> 1;
    end
    send_flag();
    idle(8);
    expect_drained("residual12");
  endtask

  task automatic test_word_full();
    int         w0;
    logic [7:0] s;
    logic [7:0] bytes [4];
    bytes[0] = 8'h01; bytes[1] = 8'h23; bytes[2] = 8'h45; bytes[3] = 8'h67;
    push_word(16'h2301, 1'b0);
    push_word(16'h6745, 1'b0);
    push_end(1'b1, 4, 1'b1);
    w0 = n_words;
    word_full = 1'b1;
    send_flag();
    for (int k = 0; k < 4; k++) begin
      s = bytes[k];
      for (int i = 0; i < 8; i++) begin
        send_stuffed(s[0]);
        s = s >> 1;
        if (n_words > w0) word_full = 1'b0;
      end
    end
    word_full = 1'b0;
    send_flag();
    idle(8);
    expect_drained("word_full");
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
    push_word(16'h2211, 1'b0);
    push_word(16'h4433, 1'b0);
    push_end(1'b0, 4, 1'b0);
    send_flag();
    send_byte(8'h11); send_byte(8'h22);
    n_checks++;
    if (overrun !== 1'b0 || in_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_clear: got overrun=%b in_frame=%b, required overrun=0 in_frame=1", overrun, in_frame);
    end
    send_byte(8'h33); send_byte(8'h44);
    send_flag();
    idle(8);
    expect_drained("overrun_next");
  endtask

  task automatic test_enable();
    logic [3:0] r;
    send_flag();
    send_byte(8'h5A);
    r = 4'h6;
    for (int i = 0; i < 4; i++) begin
      send_stuffed(r[0]);
      r = r >> 1;
    end
    n_checks++;
    if (in_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_pre_in_frame: got %b, required 1", in_frame);
    end
    enable = 1'b0;
    repeat (2) step();
    n_checks++;
    if (in_frame !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_low: got in_frame=%b overrun=%b, required 0 0", in_frame, overrun);
    end
    send_flag();
    send_byte(8'h12);
    enable = 1'b1;
    idle(4);
    push_word(16'h2301, 1'b0);
    push_word(16'h6745, 1'b0);
    push_end(1'b0, 4, 1'b0);
    send_flag();
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
    send_flag();
    idle(8);
    expect_drained("enable");
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    n_words = 0; n_start = 0; n_abort = 0; n_end = 0;
    cyc = 0; last_odd_cyc = -1; last_end_cyc = -2;
    tx_ones = 0; ignore_words = 1'b0;
    reset_n = 1'b0; rx_clk = 1'b0; rx_data = 1'b1; enable = 1'b0; word_full = 1'b0;

    test_reset();
    test_idle_line();
    test_basic_frame();
    test_stuffing();
    test_odd_byte();
    test_abort();
    test_bad_length();
    test_word_full();
    test_enable();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdlc_rx_deframer.md
Name: sdlc_rx_deframer

Overview:
Line-side front end of the SDLC receive path. It sits directly upstream of the receive CRC/FIFO datapath.
- Samples the external rx_clk/rx_data pair.
- Hunts for 0x7E flags, removes zero-insertion and detects aborts.
- Assembles destuffed bits LSB-first into 16-bit words with frame start/end status.
- Output words are written straight into the datapath's 16-bit receive FIFO (two 8-bit halves).

Parameters:
SYNC_STAGES, 2, synchroniser depth on rx_clk and rx_data (min 2)
MIN_BYTES, 4, minimum legal frame length in bytes (data + 16-bit CRC)
MAX_BYTES, 256, maximum legal frame length; also sets byte_count width = clog2(MAX_BYTES+1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
rx_clk  in  1  recovered/line bit clock, asynchronous to clk
rx_data  in  1  line data, valid at rx_clk rising edge
enable  in  1  receiver enable; low forces HUNT
word_full  in  1  downstream FIFO full, sampled when word_valid is high
word_data  out  16  assembled word; first received bit = bit 0
word_valid  out  1  one-clk write strobe into downstream FIFO
word_odd  out  1  with word_valid: only word_data[7:0] valid (final odd byte)
frame_start  out  1  one-clk pulse on first data bit after a flag
frame_end  out  1  one-clk pulse on closing flag of a frame
frame_err  out  1  valid with frame_end: frame status bad
byte_count  out  clog2(MAX_BYTES+1)  valid with frame_end: destuffed bytes in frame
abort  out  1  one-clk pulse on abort inside a frame
overrun  out  1  sticky; set when word_valid coincides with word_full; cleared by frame_start or !enable
in_frame  out  1  high while state = FRAME

Behaviour:
- Reset: all outputs 0, state HUNT, all counters and shifters cleared. Reset mid-frame drops the frame with no frame_end.
- Input synchronisation:
  - rx_clk and rx_data pass through SYNC_STAGES flops.
  - A bit event is a 0->1 transition of the synchronised rx_clk.
  - The synchronised rx_data is captured in the event cycle.
- Ones counter, per bit event (saturates at 7):
  - bit 1: ones++. Reaching 7 is an abort: in FRAME, pulse abort the next clk; in any state, go to HUNT.
  - bit 0 with ones==6: flag.
  - bit 0 with ones==5: stuffed zero, discarded.
  - any other 0: data zero.
  - Every 0 resets ones to 0.
- Delay line:
  - Destuffed bits enter a 7-deep delay line. Bits reach the word assembler only when pushed out by a later destuffed bit.
  - On a flag, the delay line contents (the flag's leading 0 and six 1s) are discarded.
- States:
  - HUNT: ignore data. Flag -> SYNC.
  - SYNC: a flag stays in SYNC (back-to-back or shared flags give no output). The first bit exiting the delay line -> FRAME, frame_start pulse, byte count cleared, overrun cleared.
  - FRAME: bits fill the assembler LSB-first.
    - On the 16th bit: word_valid for 1 clk, the clk after the event cycle.
    - On a flag: frame_end 1 clk after the flag event, then -> SYNC.
    - On abort: -> HUNT.
- Frame end:
  - 8 residual bits: word_valid with word_odd=1 in the same clk as frame_end; word_data[15:8]=0.
  - frame_err=1 if any of: residual bits not 0 or 8; byte_count < MIN_BYTES; byte_count > MAX_BYTES; overrun set during the frame.
  - byte_count saturates at MAX_BYTES+1. Words beyond MAX_BYTES are not emitted.
- Simultaneity: a flag and a word completion cannot coincide, because the delay line is discarded on a flag.
- word_full: the word is still strobed (FIFO drops it) and overrun is set.
- enable low: -> HUNT next clk; counters, delay line and overrun cleared; no frame_end. A frame in progress is dropped silently.
- Idle line (continuous 1s): stays HUNT, with no repeated abort pulses outside FRAME.

Optional Feature:
SDLC_RX_NRZI_EN
- Defined: an NRZI decoder precedes the ones counter. Decoded bit = 1 if the sampled level equals the previous sampled level, else 0. The previous level resets to 1, and is updated every bit event, including while enable is low.
- Not defined: rx_data is NRZ and feeds the ones counter directly; no extra logic.
- Output timing is identical in both builds.

Test Plan:
- Flags 7E 7E, bytes 01 23 45 67, flag 7E -> frame_start once; word_valid with 0x2301 then 0x6745; frame_end with byte_count=4, frame_err=0.
- Frame FF FF 1F 00 sent with zero insertion after every five 1s -> words 0xFFFF, 0x001F; no spurious flag or abort; byte_count=4, frame_err=0.
- Five bytes 01 23 45 67 89 -> third word_valid with word_odd=1 and word_data=0x0089, in the same clk as frame_end; byte_count=5, frame_err=0.
- Abort after 2 data bytes (seven 1s), then flag and a valid 4-byte frame -> abort pulse, no frame_end for the first frame; the second frame has frame_end with frame_err=0.
- Two-byte frame -> frame_end, frame_err=1, byte_count=2. A frame with 12 residual bits (count 4 + 12 bits) -> frame_err=1.
- word_full=1 on the first word of a 4-byte frame -> overrun=1, frame_err=1 at frame_end. The next frame_start clears overrun.
